sha256_id_issue: RTL and testbench

- Generates the ID stream consumed by the config synchroniser's id_in port: one 6-bit ID per hash request, issued in sequence with wrap-around.
- Tracks outstanding IDs and accepts retirements from the hash output side. Back-pressures issue when the in-flight limit is reached.
- Flags any out-of-order retirement as an error.

---
 rtl/sha256_id_issue.sv | 86 ++++++++
 tb/tb_sha256_id_issue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_id_issue.sv
// sha256_id_issue: issues sequential hash request IDs,
// tracks in-flight IDs and flags out-of-order retirement.
module sha256_id_issue #(
  parameter int ID_W            = 6,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic            clk,
  input  logic            sync_rst,
  input  logic            en,
  output logic [ID_W-1:0] id_out,
  output logic            id_out_last,
  output logic            id_out_valid,
  input  logic            id_out_ready,
  input  logic [ID_W-1:0] id_ret,
  input  logic            id_ret_valid,
  output logic            id_ret_ready,
  output logic [ID_W:0]   outstanding,
  output logic            err
);

  localparam logic [ID_W:0] MAX_C =
    (ID_W+1)'(MAX_OUTSTANDING);
  localparam logic [ID_W:0] ONE_C =
    (ID_W+1)'(1);

  logic [ID_W-1:0] next_id;
  logic [ID_W-1:0] exp_ret;
  logic            issue_hs;
  logic            ret_hs;
  logic            load;
  logic            valid_nxt;
  logic [ID_W:0]   out_nxt;

  assign id_ret_ready = (outstanding != '0);

  // Handshakes, next in-flight count and issue-slot reload decision.
  always_comb begin
    issue_hs = id_out_valid && id_out_ready;
    ret_hs   = id_ret_valid && id_ret_ready;
    out_nxt  = outstanding;
    if (issue_hs && !ret_hs)
      out_nxt = outstanding + ONE_C;
    else if (!issue_hs && ret_hs)
      out_nxt = outstanding - ONE_C;
    load      = !id_out_valid || issue_hs;
    valid_nxt = en && (out_nxt < MAX_C);
  end

  // Issue slot: holds a presented ID until accepted, then reloads.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      id_out       <= '0;
      id_out_last  <= 1'b0;
      id_out_valid <= 1'b0;
      next_id      <= '0;
    end else if (load) begin
      id_out_valid <= valid_nxt;
      if (valid_nxt) begin
        id_out      <= next_id;
        id_out_last <= &next_id;
        next_id     <= next_id + ID_W'(1);
      end
    end
  end

  // In-flight counter over accepted issues and retirements.
  always_ff @(posedge clk) begin
    if (sync_rst)
      outstanding <= '0;
    else
      outstanding <= out_nxt;
  end

  // Retire-order check; err is sticky until reset.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      exp_ret <= '0;
      err     <= 1'b0;
    end else if (ret_hs) begin
      exp_ret <= exp_ret + ID_W'(1);
      if (id_ret != exp_ret)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha256_id_issue.sv
// tb_sha256_id_issue: table, directed and random checks
// of sha256_id_issue against a queue-based reference model.
module tb_sha256_id_issue;

  localparam int MAXO = 16;

  logic       clk = 1'b0;
  logic       rst, en, rdy, rv;
  logic [5:0] rid;
  logic [5:0] id_out;
  logic       last, valid, rready, err;
  logic [6:0] outst;

  logic       w_rst, w_en, w_rdy, w_rv;
  logic [5:0] w_rid, w_id;
  logic       w_last, w_valid, w_rready, w_err;
  logic [6:0] w_outst;

  always #5 clk = ~clk;

  sha256_id_issue #(.ID_W(6), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .sync_rst(rst), .en(en),
    .id_out(id_out), .id_out_last(last),
    .id_out_valid(valid), .id_out_ready(rdy),
    .id_ret(rid), .id_ret_valid(rv),
    .id_ret_ready(rready), .outstanding(outst),
    .err(err)
  );

  sha256_id_issue #(.ID_W(6), .MAX_OUTSTANDING(64)) dut64 (
    .clk(clk), .sync_rst(w_rst), .en(w_en),
    .id_out(w_id), .id_out_last(w_last),
    .id_out_valid(w_valid), .id_out_ready(w_rdy),
    .id_ret(w_rid), .id_ret_valid(w_rv),
    .id_ret_ready(w_rready), .outstanding(w_outst),
    .err(w_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Reference model: FIFO of accepted IDs plus one issue slot.
  int q[$];
  bit m_pv;
  int m_pid;
  int m_nid;
  bit m_err;

  task automatic model_edge();
    bit iss, ret;
    int f;
    if (rst) begin
      q.delete();
      m_pv = 0; m_pid = 0; m_nid = 0; m_err = 0;
      return;
    end
    iss = m_pv && rdy;
    ret = rv && (q.size() != 0);
    if (ret) begin
      f = q.pop_front();
      if (f != int'(rid)) m_err = 1;
    end
    if (iss) q.push_back(m_pid);
    if (!m_pv || iss) begin
      m_pv = en && (q.size() < MAXO);
      if (m_pv) begin
        m_pid = m_nid;
        m_nid = (m_nid + 1) % 64;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_valid", 32'(valid), 32'(m_pv));
    chk("model_outstanding", 32'(outst), q.size());
    chk("model_ret_ready", 32'(rready), 32'(q.size() != 0));
    chk("model_err", 32'(err), 32'(m_err));
    if (m_pv) begin
      chk("model_id", 32'(id_out), m_pid);
      chk("model_last", 32'(last), 32'(m_pid == 63));
    end
  endtask

  typedef struct {
    logic       en, rdy, rv;
    logic [5:0] rid;
    logic       ev;
    logic [5:0] eid;
    logic [6:0] eout;
    logic       err_rdy;
  } vec_t;

  vec_t tbl[20];

  initial begin
    int n;
    int wexp, wret, nlast;
    bit whs, wrh;

    for (int k = 0; k < 16; k++)
      tbl[k] = '{1, 1, 0, 6'd0, 1, 6'(k), 7'(k), k != 0};
    tbl[16] = '{1, 1, 0, 6'd0, 0, 6'd0, 7'd16, 1};
    tbl[17] = '{1, 1, 0, 6'd0, 0, 6'd0, 7'd16, 1};
    tbl[18] = '{1, 1, 1, 6'd0, 1, 6'd16, 7'd15, 1};
    tbl[19] = '{1, 1, 0, 6'd0, 0, 6'd0, 7'd16, 1};

    w_rst = 1; w_en = 0; w_rdy = 0; w_rv = 0; w_rid = 0;
    rst = 1; en = 0; rdy = 0; rv = 0; rid = 0;
    step();
    chk("rst_id", 32'(id_out), 0);
    chk("rst_last", 32'(last), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_outst", 32'(outst), 0);
    chk("rst_err", 32'(err), 0);

    // fill to the limit, idle full, then recover
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      en = tbl[i].en; rdy = tbl[i].rdy;
      rv = tbl[i].rv; rid = tbl[i].rid;
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_outst", i), 32'(outst), 32'(tbl[i].eout));
      chk($sformatf("tbl%0d_rready", i), 32'(rready),
          32'(tbl[i].err_rdy));
      if (tbl[i].ev)
        chk($sformatf("tbl%0d_id", i), 32'(id_out), 32'(tbl[i].eid));
    end

    // ready stall on ID 3 with en dropped mid-stall
    rst = 1; rv = 0; step();
    rst = 0; en = 1; rdy = 1;
    for (int i = 0; i < 4; i++) step();
    chk("stall_pres_id", 32'(id_out), 3);
    rdy = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) en = 0;
      step();
      chk("stall_id", 32'(id_out), 3);
      chk("stall_valid", 32'(valid), 1);
      chk("stall_outst", 32'(outst), 3);
    end
    rdy = 1; step();
    chk("stall_xfer_outst", 32'(outst), 4);
    chk("stall_xfer_valid", 32'(valid), 0);
    step();
    chk("stall_no_valid", 32'(valid), 0);

    // simultaneous issue/retire, then an out-of-order retire
    en = 1; step(); step();
    chk("sim_pre_outst", 32'(outst), 5);
    rv = 1; rid = 0; step();
    chk("sim_outst", 32'(outst), 5);
    rid = 1; rdy = 0; step();
    chk("sim_exp_adv_err", 32'(err), 0);
    rid = 9; step();
    chk("bad_ret_err", 32'(err), 1);
    for (int i = 0; i < 2; i++) begin
      rid = 6'(q[0]); step();
      chk("err_sticky", 32'(err), 1);
    end

    // drain, refill to 7 in flight, reset mid-handshake
    n = 0;
    while (q.size() != 0 && n < 100) begin
      rid = 6'(q[0]); step(); n++;
    end
    chk("drain_bound", 32'(q.size()), 0);
    rv = 0; en = 1; rdy = 1; n = 0;
    while (!(q.size() == 7 && m_pv) && n < 100) begin
      step(); n++;
    end
    chk("fill7_outst", 32'(outst), 7);
    rst = 1; step();
    chk("mrst_id", 32'(id_out), 0);
    chk("mrst_last", 32'(last), 0);
    chk("mrst_valid", 32'(valid), 0);
    chk("mrst_outst", 32'(outst), 0);
    chk("mrst_err", 32'(err), 0);
    rst = 0; step();
    chk("mrst_first_id", 32'(id_out), 0);
    chk("mrst_first_valid", 32'(valid), 1);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      en  = ($urandom_range(0, 7) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      rv  = ($urandom_range(0, 2) != 0);
      if (q.size() != 0 && $urandom_range(0, 29) != 0)
        rid = 6'(q[0]);
      else
        rid = 6'($urandom);
      step();
    end

    // wrap across two epochs with a 64-deep instance
    rst = 1; en = 0; rdy = 0; rv = 0; step();
    @(posedge clk); #1;
    w_rst = 0; w_en = 1; w_rdy = 1; w_rv = 1;
    wexp = 0; wret = 0; nlast = 0;
    for (int i = 0; i < 140; i++) begin
      w_rid = 6'(wret % 64);
      whs = w_valid && w_rdy;
      wrh = w_rv && w_rready;
      @(posedge clk); #1;
      if (whs) wexp++;
      if (wrh) wret++;
      chk("wrap_valid", 32'(w_valid), 1);
      chk("wrap_id", 32'(w_id), wexp % 64);
      chk("wrap_last", 32'(w_last), 32'((wexp % 64) == 63));
      chk("wrap_err", 32'(w_err), 0);
      if (w_valid && w_last) nlast++;
    end
    chk("wrap_epochs", 32'(nlast >= 2), 1);
    chk("wrap_retired", 32'(wret >= 128), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
